// File: rtl/mdu_pkg.sv
// Shared types for the execute-stage multiply/divide unit.
// Holds the op encoding, control state encoding, datapath widths and the
// pending-result payload struct.
package mdu_pkg;

    localparam int unsigned MDU_OP_W = 4;
    localparam int unsigned XLEN     = 32;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // Result pair produced by the arithmetic block and parked until completion.
    typedef struct packed {
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } mdu_res_t;

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU bus.
// master (pipeline side): drives Req, start, op, A, B; sees busy, hilo_out, HI, LO.
// slave  (MDU side):      the reverse.
interface e_mdu_if;
    import mdu_pkg::*;

    logic                Req;
    logic                start;
    logic [MDU_OP_W-1:0] op;
    logic [XLEN-1:0]     A;
    logic [XLEN-1:0]     B;
    logic                busy;
    logic [XLEN-1:0]     hilo_out;
    logic [XLEN-1:0]     HI;
    logic [XLEN-1:0]     LO;

    modport master (
        output Req, start, op, A, B,
        input  busy, hilo_out, HI, LO
    );

    modport slave (
        input  Req, start, op, A, B,
        output busy, hilo_out, HI, LO
    );

endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath.
// Ports:
//   op_i         MDU op code
//   a_i, b_i     rs / rt operands
//   res_c_o      {hi, lo} result for mult/multu/div/divu (0 for other ops)
//   div_zero_c_o divide op with a zero divisor; result must not be committed
// Signed division runs on magnitudes through the shared unsigned divider and
// re-applies signs: quotient truncates toward zero, remainder follows the
// dividend. 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [MDU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    output mdu_res_t            res_c_o,
    output logic                div_zero_c_o
);

    localparam int unsigned PROD_W = 2 * XLEN;

    mdu_op_e           op;
    logic              is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   dvd;
    logic [XLEN-1:0]   dvs;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [PROD_W-1:0] mul_a;
    logic [PROD_W-1:0] mul_b;
    logic [PROD_W-1:0] prod;

    assign op        = mdu_op_e'(op_i);
    assign is_signed = (op == MDU_MULT) || (op == MDU_DIV);
    assign a_neg     = is_signed && a_i[XLEN-1];
    assign b_neg     = is_signed && b_i[XLEN-1];

    // Single 64x64 multiplier; extension choice picks signed vs unsigned.
    assign mul_a = is_signed ? {{XLEN{a_i[XLEN-1]}}, a_i} : {{XLEN{1'b0}}, a_i};
    assign mul_b = is_signed ? {{XLEN{b_i[XLEN-1]}}, b_i} : {{XLEN{1'b0}}, b_i};
    assign prod  = mul_a * mul_b;

    // Single unsigned divider fed with magnitudes; zero divisor steered to 1
    // so the divider never sees 0 (result is discarded anyway).
    assign a_mag = a_neg ? (~a_i + XLEN'(1)) : a_i;
    assign b_mag = b_neg ? (~b_i + XLEN'(1)) : b_i;
    assign dvd   = a_mag;
    assign dvs   = (b_mag == '0) ? XLEN'(1) : b_mag;
    assign quo   = dvd / dvs;
    assign rem   = dvd % dvs;

    // Result select per op.
    always_comb begin
        res_c_o      = '0;
        div_zero_c_o = 1'b0;
        case (op)
            MDU_MULT, MDU_MULTU: begin
                res_c_o.hi = prod[PROD_W-1:XLEN];
                res_c_o.lo = prod[XLEN-1:0];
            end
            MDU_DIV, MDU_DIVU: begin
                res_c_o.lo   = (a_neg ^ b_neg) ? (~quo + XLEN'(1)) : quo;
                res_c_o.hi   = a_neg ? (~rem + XLEN'(1)) : rem;
                div_zero_c_o = (b_i == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit; owns architectural HI/LO.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         e_mdu_if slave: Req/start/op/A/B in; busy/hilo_out/HI/LO out
// mult/div results are computed at the accept edge, parked in pend_*, and
// committed to HI/LO when the down-counter expires, so HI/LO change exactly
// MULT_CYCLES / DIV_CYCLES edges after (and counting) the accept edge.
// Both latencies must be at least 2.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic    clk,
    input logic    reset,
    e_mdu_if.slave bus
);

    localparam int unsigned MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    mdu_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [XLEN-1:0] hi_q,    hi_d;
    logic [XLEN-1:0] lo_q,    lo_d;
    mdu_res_t        pend_q,  pend_d;
    logic            pend_wr_q, pend_wr_d;

    mdu_op_e  op;
    logic     accept;
    mdu_res_t arith_res;
    logic     div_zero;

    assign op     = mdu_op_e'(bus.op);
    assign accept = bus.start && !bus.Req && (state_q == ST_IDLE);

    mdu_arith u_arith (
        .op_i         (bus.op),
        .a_i          (bus.A),
        .b_i          (bus.B),
        .res_c_o      (arith_res),
        .div_zero_c_o (div_zero)
    );

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_q    <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    // Next-state: accept in IDLE, count down in RUN, commit on expiry.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        MDU_MULT, MDU_MULTU: begin
                            pend_d    = arith_res;
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES - 1);
                            state_d   = ST_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_d    = arith_res;
                            pend_wr_d = !div_zero;
                            cnt_d     = CNT_W'(DIV_CYCLES - 1);
                            state_d   = ST_RUN;
                        end
                        MDU_MTHI: hi_d = bus.A;
                        MDU_MTLO: lo_d = bus.A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // Req and start are ignored here: the op already left E.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (pend_wr_q) begin
                        hi_d = pend_q.hi;
                        lo_d = pend_q.lo;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    // mfhi/mflo read port; decoded straight from op.
    always_comb begin
        bus.hilo_out = '0;
        case (op)
            MDU_MFHI: bus.hilo_out = hi_q;
            MDU_MFLO: bus.hilo_out = lo_q;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios plus random traffic, all compared every
// cycle against an arithmetic reference model of HI/LO and the busy window.
module tb_e_mdu;
    import mdu_pkg::*;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_if bus();

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result {write_enable, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up, uq, ur;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        ref_op = '0;
        case (op)
            4'd1: begin p = sa * sb; ref_op = {1'b1, 64'(p)}; end
            4'd2: begin up = ua * ub; ref_op = {1'b1, 64'(up)}; end
            4'd3: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                ref_op = {1'b1, 32'(r), 32'(q)};
            end
            4'd4: if (b != 0) begin
                uq = ua / ub;
                ur = ua % ub;
                ref_op = {1'b1, 32'(ur), 32'(uq)};
            end
            default: ;
        endcase
    endfunction

    // Model: architectural HI/LO plus edges remaining until the pending commit.
    logic [31:0] m_hi = '0, m_lo = '0, m_ph = '0, m_pl = '0;
    logic        m_wr = 1'b0;
    int          m_left = 0;
    logic        seen = 1'b0;

    always @(posedge clk) begin
        seen <= 1'b1;
        if (reset) begin
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1 && m_wr) begin
                m_hi <= m_ph;
                m_lo <= m_pl;
            end
        end else if (bus.start && !bus.Req) begin
            {m_wr, m_ph, m_pl} <= ref_op(bus.op, bus.A, bus.B);
            case (bus.op)
                4'd1, 4'd2: m_left <= MC - 1;
                4'd3, 4'd4: m_left <= DC - 1;
                4'd7:       m_hi   <= bus.A;
                4'd8:       m_lo   <= bus.A;
                default: ;
            endcase
        end
    end

    // Per-cycle compare, sampled just after inputs settle mid-cycle.
    always @(negedge clk) begin
        #1;
        if (seen) begin
            check32("busy", 32'(bus.busy), 32'(m_left > 0));
            check32("HI", bus.HI, m_hi);
            check32("LO", bus.LO, m_lo);
            check32("hilo_out", bus.hilo_out,
                    (bus.op == 4'd5) ? m_hi : ((bus.op == 4'd6) ? m_lo : 32'd0));
        end
    end

    task automatic drive(input logic s, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic r, input logic rst);
        @(negedge clk);
        reset     = rst;
        bus.start = s;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        bus.Req   = r;
    endtask

    task automatic idle(input logic [3:0] o);
        drive(1'b0, o, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    // Issue one op, then idle (reading LO) long enough to cover any latency.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cnt);
        drive(1'b1, o, a, b, 1'b0, 1'b0);
        busy_cnt = 0;
        repeat (DC + 1) begin
            idle(4'd6);
            #1;
            if (bus.busy) busy_cnt++;
        end
        #1;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: pick = 32'd0;
            1: pick = 32'hFFFF_FFFF;
            2: pick = 32'h8000_0000;
            3: pick = 32'd1;
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        int bc;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Req   = 1'b0;
        repeat (3) drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle(4'd5);
        #2;
        check32("rst_busy", 32'(bus.busy), 32'd0);
        check32("rst_hi", bus.HI, 32'd0);
        check32("rst_lo", bus.LO, 32'd0);
        check32("rst_hilo", bus.hilo_out, 32'd0);

        // mult -2 * 3
        run_op(4'd1, 32'hFFFF_FFFE, 32'd3, bc);
        check32("mult_busy_cycles", bc, 32'd4);
        check32("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check32("mult_lo", bus.LO, 32'hFFFF_FFFA);
        check32("mult_mflo", bus.hilo_out, 32'hFFFF_FFFA);
        check32("model_mult_lo", m_lo, 32'hFFFF_FFFA);

        // divu 100 / 7, div -7 / 2
        run_op(4'd4, 32'd100, 32'd7, bc);
        check32("divu_busy_cycles", bc, 32'd9);
        check32("divu_lo", bus.LO, 32'd14);
        check32("divu_hi", bus.HI, 32'd2);
        check32("model_divu_hi", m_hi, 32'd2);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2, bc);
        check32("div_lo", bus.LO, 32'hFFFF_FFFD);
        check32("div_hi", bus.HI, 32'hFFFF_FFFF);
        check32("model_div_lo", m_lo, 32'hFFFF_FFFD);

        // mthi then mfhi
        drive(1'b1, 4'd7, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        idle(4'd5);
        #2;
        check32("mthi_mfhi", bus.hilo_out, 32'h1234_5678);
        check32("mthi_busy", 32'(bus.busy), 32'd0);

        // multu flushed by Req in the same cycle
        drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        bc = 0;
        repeat (6) begin
            idle(4'd0);
            #1;
            if (bus.busy) bc++;
        end
        check32("flush_busy_cycles", bc, 32'd0);
        check32("flush_hi", bus.HI, 32'h1234_5678);
        check32("flush_lo", bus.LO, 32'hFFFF_FFFD);

        // multu with Req and an illegal start during RUN
        drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd8, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd8, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        repeat (4) idle(4'd0);
        #2;
        check32("multu_hi", bus.HI, 32'hFFFF_FFFE);
        check32("multu_lo", bus.LO, 32'h0000_0001);
        check32("model_multu_hi", m_hi, 32'hFFFF_FFFE);

        // divide by zero leaves HI/LO alone; then the signed overflow corner
        drive(1'b1, 4'd7, 32'd5, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd8, 32'd9, 32'd0, 1'b0, 1'b0);
        run_op(4'd3, 32'd123, 32'd0, bc);
        check32("divz_busy_cycles", bc, 32'd9);
        check32("divz_hi", bus.HI, 32'd5);
        check32("divz_lo", bus.LO, 32'd9);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc);
        check32("divovf_lo", bus.LO, 32'h8000_0000);
        check32("divovf_hi", bus.HI, 32'd0);
        check32("model_divovf_lo", m_lo, 32'h8000_0000);

        // reset in the middle of a div
        drive(1'b1, 4'd3, 32'd1000, 32'd3, 1'b0, 1'b0);
        idle(4'd0);
        idle(4'd0);
        drive(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle(4'd0);
        #2;
        check32("rstmid_busy", 32'(bus.busy), 32'd0);
        check32("rstmid_hi", bus.HI, 32'd0);
        check32("rstmid_lo", bus.LO, 32'd0);
        repeat (DC) idle(4'd0);
        #2;
        check32("rstmid_late_lo", bus.LO, 32'd0);
        run_op(4'd1, 32'd6, 32'd7, bc);
        check32("mult67_lo", bus.LO, 32'd42);
        check32("mult67_hi", bus.HI, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick(),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
        end
        idle(4'd0);
        repeat (DC + 2) idle(4'd5);
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the P7 pipeline.
- Runs mult/multu/div/divu as multi-cycle operations and owns the architectural HI/LO registers.
- Serves mfhi/mflo reads and performs mthi/mtlo writes.
- Its hilo_out feeds the EX/MEM register's HILO input; busy feeds the hazard unit's stall logic.

Parameters:
- MULT_CYCLES, 5, cycles from accepted mult/multu to HI/LO update.
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO update.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Req  in  1  exception/interrupt flush; cancels the E-stage instruction this cycle
- start  in  1  E-stage instruction is an MDU op and is valid (not stalled, not bubble)
- op  in  4  MDU operation code (package enum)
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- busy  out  1  operation in flight
- hilo_out  out  32  HI for MFHI, LO for MFLO, else 0
- HI  out  32  architectural HI
- LO  out  32  architectural LO

Behaviour:
- Reset: HI=0, LO=0, busy=0, state IDLE, counter=0, pending registers=0. hilo_out=0 because op decode is combinational and HI=LO=0.
- Reset has priority over everything. Reset mid-operation aborts without updating HI/LO.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter cnt active.
- Accept condition: start && !Req && state==IDLE.
- IDLE accepting MULT/MULTU/DIV/DIVU:
  - Compute the result at the accept edge; latch pend_hi/pend_lo.
  - Load cnt = latency-1, go to RUN.
  - busy rises the cycle after start.
  - The hazard unit stalls on start||busy; this block does not combine them.
- RUN: cnt decrements each cycle. When cnt==1, on the next edge: HI<=pend_hi, LO<=pend_lo, state->IDLE, busy->0.
  - Net result: HI/LO are visible exactly MULT_CYCLES (DIV_CYCLES) edges after the accept edge.
  - busy is high for latency-1 cycles.
- MTHI/MTLO (accepted in IDLE): HI<=A or LO<=A at that edge; no busy.
- MFHI/MFLO: hilo_out combinational from current HI/LO. Reading during RUN returns the old value; upstream must stall.
- Req: any start in the same cycle is ignored (flushed instruction). A RUN already in progress continues to completion, because the instruction has already committed past E.
- start while in RUN is illegal (the hazard unit prevents it) and is ignored.
- Arithmetic:
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - DIVU: unsigned quotient/remainder.
  - Divide by zero (B==0): full DIV_CYCLES latency, busy as normal, HI/LO unchanged at completion.
- Unknown op with start: no effect.
- Latency must be >=2. Parameters below 2 are unsupported.

Decomposition:
- Shared package mdu_pkg holds:
  - op enum: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8
  - MDU_OP_W=4
  - state enum IDLE/RUN
- One sub-module, mdu_arith: combinational compute of pend_hi/pend_lo from op/A/B, including signed-division corner handling and the div-by-zero flag.
- Control FSM and HI/LO registers stay in e_mdu.

Test Plan:
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high for 4 cycles; 5 edges after start HI=0xFFFFFFFF, LO=0xFFFFFFFA; hilo_out for MFLO = 0xFFFFFFFA.
- DIVU A=100, B=7 -> busy for 9 cycles; afterwards LO=14, HI=2. DIV A=-7 (0xFFFFFFF9), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x12345678, then MFHI next cycle -> hilo_out=0x12345678, busy stays 0.
- MULTU start with Req=1 same cycle (A=B=0xFFFFFFFF) -> busy never rises, HI/LO unchanged. Repeat with Req pulsed during RUN -> completes, HI=0xFFFFFFFE, LO=0x00000001.
- DIV with B=0 after HI=5, LO=9 -> busy for 9 cycles, HI=5, LO=9 afterwards. Then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- reset asserted at cycle 3 of a DIV -> next cycle busy=0, HI=LO=0, no later update; a new MULT 6*7 then gives LO=42, HI=0.
